// File: rtl/im_arbiter.sv
// Fetch/debug arbiter for the instruction-memory read port, with byte-to-word address checking.
// Grant is combinational; the response follows one cycle after the grant. Fetch has priority, and a starvation counter lets debug through.
module im_arbiter #(
   parameter int unsigned ADDR_W       = 12,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   output logic              f_err,
   input  logic              d_req,
   input  logic [31:0]       d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_idx,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [29:0]       w_f_word, w_d_word;
   logic              w_f_bad, w_d_bad, w_d_win, w_gnt_bad;
   logic              r_pend_valid, r_owner_d, r_pend_err;
   logic [3:0]        r_starve_cnt;

   // Below-base addresses wrap to huge offsets, but the explicit compare keeps them bad for any BASE_ADDR.
   assign w_f_word = 30'((f_addr - BASE_ADDR) >> 2);
   assign w_d_word = 30'((d_addr - BASE_ADDR) >> 2);
   assign w_f_bad  = (f_addr < BASE_ADDR) | (|w_f_word[29:ADDR_W]) | (|f_addr[1:0]);
   assign w_d_bad  = (d_addr < BASE_ADDR) | (|w_d_word[29:ADDR_W]) | (|d_addr[1:0]);

   assign w_d_win = d_req & (r_starve_cnt == LIMIT);
   assign f_gnt   = f_req & ~w_d_win;
   assign d_gnt   = d_req & (w_d_win | ~f_req);

   always_comb begin
      mem_en    = 1'b0;
      mem_idx   = '0;
      w_gnt_bad = 1'b0;
      if (f_gnt) begin
         mem_en    = ~w_f_bad;
         mem_idx   = w_f_bad ? '0 : w_f_word[ADDR_W-1:0];
         w_gnt_bad = w_f_bad;
      end else if (d_gnt) begin
         mem_en    = ~w_d_bad;
         mem_idx   = w_d_bad ? '0 : w_d_word[ADDR_W-1:0];
         w_gnt_bad = w_d_bad;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_valid <= 1'b0;
         r_owner_d    <= 1'b0;
         r_pend_err   <= 1'b0;
         r_starve_cnt <= 4'd0;
      end else begin
         r_pend_valid <= f_gnt | d_gnt;
         r_owner_d    <= d_gnt;
         r_pend_err   <= w_gnt_bad;
         if (!d_req || d_gnt)
            r_starve_cnt <= 4'd0;
         else if (r_starve_cnt != LIMIT)
            r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   assign f_rvalid = r_pend_valid & ~r_owner_d;
   assign d_rvalid = r_pend_valid & r_owner_d;
   assign f_err    = f_rvalid & r_pend_err;
   assign d_err    = d_rvalid & r_pend_err;
   assign f_rdata  = (f_rvalid & ~r_pend_err) ? mem_rdata : 32'd0;
   assign d_rdata  = (d_rvalid & ~r_pend_err) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_im_arbiter.sv
// Bench for im_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_im_arbiter;

   localparam int unsigned ADDR_W       = 12;
   localparam logic [31:0] BASE_ADDR    = 32'h0000_3000;
   localparam int unsigned STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              f_req, d_req;
   logic [31:0]       f_addr, d_addr;
   logic              f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
   logic [31:0]       f_rdata, d_rdata;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_idx;
   logic [31:0]       mem_rdata = 32'd0;

   int checks   = 0;
   int failures = 0;

   // Reference model state: the pending response and the count of lost debug cycles.
   int m_lost   = 0;
   bit m_pv     = 0;
   bit m_own_d  = 0;
   bit m_err    = 0;
   int m_idx    = 0;

   im_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_idx(mem_idx), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input int idx);
      return 32'hC0DE_0000 ^ (32'(idx) * 32'h0101_0101);
   endfunction

   always @(posedge clk) if (mem_en) mem_rdata <= memf(int'(mem_idx));

   function automatic bit addr_bad(input logic [31:0] a);
      longint unsigned ua = longint'(a);
      longint unsigned lo = longint'(BASE_ADDR);
      longint unsigned hi = lo + 4 * (longint'(1) << ADDR_W);
      return (ua < lo) || (ua >= hi) || (ua % 4 != 0);
   endfunction

   function automatic int addr_idx(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE_ADDR)) / 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check combinational and response outputs, advance model.
   task automatic step(input bit rn, input bit fr, input logic [31:0] fa,
                       input bit dr, input logic [31:0] da, input bit kill,
                       output bit eg_f, output bit eg_d, output bit og_d);
      bit dwin, gbad;
      int gidx;
      logic [31:0] exp_dat;
      @(posedge clk); #1;
      reset = rn; f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
      if (!rn) begin m_lost = 0; m_pv = 0; end
      #3;
      dwin = dr && (m_lost >= int'(STARVE_LIMIT));
      eg_f = fr && !dwin;
      eg_d = dr && !eg_f;
      gbad = eg_f ? addr_bad(fa) : addr_bad(da);
      gidx = eg_f ? addr_idx(fa) : addr_idx(da);
      og_d = d_gnt;
      chk("f_gnt", 32'(f_gnt), 32'(eg_f));
      chk("d_gnt", 32'(d_gnt), 32'(eg_d));
      chk("mem_en", 32'(mem_en), 32'((eg_f || eg_d) && !gbad));
      chk("mem_idx", 32'(mem_idx), ((eg_f || eg_d) && !gbad) ? 32'(gidx) : 32'd0);
      exp_dat = m_err ? 32'd0 : memf(m_idx);
      chk("f_rvalid", 32'(f_rvalid), 32'(m_pv && !m_own_d));
      chk("f_err", 32'(f_err), 32'(m_pv && !m_own_d && m_err));
      chk("f_rdata", f_rdata, (m_pv && !m_own_d) ? exp_dat : 32'd0);
      chk("d_rvalid", 32'(d_rvalid), 32'(m_pv && m_own_d));
      chk("d_err", 32'(d_err), 32'(m_pv && m_own_d && m_err));
      chk("d_rdata", d_rdata, (m_pv && m_own_d) ? exp_dat : 32'd0);
      if (!rn || kill) begin
         m_pv = 0; m_lost = 0;
      end else begin
         m_pv    = eg_f || eg_d;
         m_own_d = eg_d;
         m_err   = gbad;
         m_idx   = gidx;
         m_lost  = (dr && !eg_d) ? ((m_lost + 1 > int'(STARVE_LIMIT)) ? int'(STARVE_LIMIT) : m_lost + 1) : 0;
      end
      if (kill) begin #2; reset = 1'b0; end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0, 1, 2, 3: return BASE_ADDR + 32'(4 * $urandom_range(0, 4095));
         4:          return BASE_ADDR + 32'h3FFC;
         5:          return BASE_ADDR + 32'h4000;
         6:          return BASE_ADDR - 32'd4;
         default:    return $urandom;
      endcase
   endfunction

   initial begin
      bit gf, gd, od, fp, dp, fr, dr;
      logic [31:0] fa, da;
      reset = 1'b0; f_req = 1'b0; d_req = 1'b0; f_addr = 32'd0; d_addr = 32'd0;

      // Reset held with fetch requesting, then first-cycle grant after release
      step(0, 1, 32'h3004, 0, 32'h0, 0, gf, gd, od);
      step(0, 1, 32'h3004, 0, 32'h0, 0, gf, gd, od);
      step(1, 1, 32'h3004, 0, 32'h0, 0, gf, gd, od);
      step(1, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);

      // Back-to-back fetch
      step(1, 1, 32'h3000, 0, 32'h0, 0, gf, gd, od);
      step(1, 1, 32'h3004, 0, 32'h0, 0, gf, gd, od);
      step(1, 1, 32'h3008, 0, 32'h0, 0, gf, gd, od);
      step(1, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);

      // Starvation: debug wins in cycles 4 and 9
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 32'h3010, 1, 32'h3100, 0, gf, gd, od);
         chk($sformatf("starve_dgnt%0d", i), 32'(od), 32'(i == 4 || i == 9));
      end
      step(1, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);

      // Bad and boundary debug addresses
      step(1, 0, 32'h0, 1, 32'h2FFC, 0, gf, gd, od);
      step(1, 0, 32'h0, 1, 32'h3002, 0, gf, gd, od);
      step(1, 0, 32'h0, 1, 32'h7000, 0, gf, gd, od);
      step(1, 0, 32'h0, 1, 32'h6FFC, 0, gf, gd, od);
      step(1, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);

      // Mid-transaction reset: granted response must never appear
      step(1, 1, 32'h3008, 0, 32'h0, 1, gf, gd, od);
      step(0, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);

      // Withdrawn debug request under fetch load; counter must restart from zero
      step(1, 1, 32'h3000, 1, 32'h3020, 0, gf, gd, od);
      step(1, 1, 32'h3000, 1, 32'h3020, 0, gf, gd, od);
      step(1, 1, 32'h3000, 0, 32'h3020, 0, gf, gd, od);
      chk("withdraw_dgnt", 32'(od), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 32'h3000, 1, 32'h3024, 0, gf, gd, od);
         chk($sformatf("restart_dgnt%0d", i), 32'(od), 32'(i == 4));
      end
      step(1, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);

      // Random traffic obeying hold-until-grant
      fp = 0; dp = 0; fa = 32'h0; da = 32'h0;
      for (int i = 0; i < 600; i++) begin
         if (!fp) begin fr = ($urandom_range(0, 3) != 0); fa = rand_addr(); end else fr = 1;
         if (!dp) begin dr = ($urandom_range(0, 2) == 0); da = rand_addr(); end else dr = 1;
         step(1, fr, fa, dr, da, 0, gf, gd, od);
         fp = fr && !gf;
         dp = dr && !gd;
      end
      step(1, 0, 32'h0, 0, 32'h0, 0, gf, gd, od);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
